seg7_scan_driver: RTL and testbench

//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_scan_driver_if.sv | 35 +++
 rtl/seg7_hex_font.sv | 14 +
 rtl/seg7_scan_driver.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the 7-segment scan driver.
//   SEG_OFF  : all segments dark (active-low bus, so every bit high).
//   HEX_FONT : 16-entry hex font, {g,f,e,d,c,b,a}, active-low.
//   idx_width: counter width for a modulus n, never less than 1 bit.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width of a counter that must hold 0..n-1. A 1-entry counter still
  // needs a real bit so that ports and compares stay well formed.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Bundles the host-side value/blanking inputs and the display-side
//   segment/anode outputs of the scan driver.
//   value_in    : packed hex digits, digit i = value_in[4i+3:4i]
//   load        : 1-cycle strobe, capture value_in
//   blank_mask  : bit i = 1 darkens digit i (sampled live)
//   seg_out     : {g,f,e,d,c,b,a}, active-low
//   an_out      : digit anodes, active-low
//   frame_start : 1-cycle pulse when the scan wraps to digit 0
//
// Handshake: load is a fire-and-forget strobe with no ready/ack. Any cycle
// with load=1 transfers value_in; the driver always accepts it, and a later
// load before the next frame boundary simply replaces the earlier one.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_start;

  // Host side: drives the value to show, observes the display.
  modport master (
    output value_in, load, blank_mask,
    input  seg_out, an_out, frame_start
  );

  // Driver side.
  modport slave (
    input  value_in, load, blank_mask,
    output seg_out, an_out, frame_start
  );
endinterface

// File: rtl/seg7_hex_font.sv
// seg7_hex_font
//   Combinational hex-to-7-segment lookup using the shared font table.
//   nibble : 4-bit hex digit
//   seg    : {g,f,e,d,c,b,a}, active-low
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on a
//   shared segment bus. A prescaler divides clk into digit slots of CLK_DIV
//   cycles; the first GUARD_CYCLES of every slot keep all anodes off so the
//   segment bus can settle without ghosting into the neighbouring digit.
//   Loaded values wait in a pending register and are committed to the shown
//   register only at the frame boundary, so a frame never mixes old and new
//   digits.
//
// Ports
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : seg7_scan_driver_if.slave (value_in, load, blank_mask in;
//         seg_out, an_out, frame_start out, all outputs registered)
//
// Parameters
//   NUM_DIGITS   : digits scanned (>=1), digit 0 = least significant nibble
//   CLK_DIV      : clk cycles per digit slot (>=GUARD_CYCLES+2)
//   GUARD_CYCLES : all-anodes-off cycles at the start of each slot (>=0)
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, digit i>0 is darkened (anode still
//   driven) while shown digits i..NUM_DIGITS-1 are all zero. Digit 0 always
//   shows. When undefined, leading zeros are displayed.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(CLK_DIV);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] DIG_LAST = IW'(NUM_DIGITS - 1);

  // Elaboration-time sanity of the configuration.
  generate
    if (NUM_DIGITS < 1) begin : g_bad_digits
      $error("seg7_scan_driver: NUM_DIGITS must be >= 1");
    end
    if (GUARD_CYCLES < 0) begin : g_bad_guard
      $error("seg7_scan_driver: GUARD_CYCLES must be >= 0");
    end
    if (CLK_DIV < GUARD_CYCLES + 2) begin : g_bad_div
      $error("seg7_scan_driver: CLK_DIV must be >= GUARD_CYCLES+2");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PW-1:0] prescaler;
  logic [IW-1:0] digit_idx;
  logic [VW-1:0] shown;
  logic [VW-1:0] pending;
  logic          pend_vld;

  // ---------------------------------------------------------------------
  // Slot / frame timing
  // ---------------------------------------------------------------------
  logic slot_end;
  logic frame_end;
  logic guard;

  assign slot_end  = (prescaler == PRE_LAST);
  // Last cycle of the last slot: the commit point and the cycle before
  // digit_idx wraps to 0.
  assign frame_end = slot_end && (digit_idx == DIG_LAST);

  // With no guard time the compare would be constant-false, so it is not
  // built at all.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign guard = 1'b0;
    end else begin : g_guard
      localparam logic [PW-1:0] GUARD_P = PW'(GUARD_CYCLES);
      assign guard = (prescaler < GUARD_P);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Leading-zero suppression (from the committed value only)
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
  logic run_zero;

  // Walk down from the most significant digit; a digit is a leading zero
  // while every digit from it upward is zero. Digit 0 is never suppressed.
  always_comb begin
    run_zero = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run_zero    = run_zero & (shown[4*i +: 4] == 4'h0);
      lz_blank[i] = run_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // ---------------------------------------------------------------------
  // Digit mux and next-output computation
  // ---------------------------------------------------------------------
  logic [3:0]            nibble;
  logic                  digit_blank;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            font_seg;
  logic [6:0]            seg_next;

  always_comb begin
    nibble      = 4'h0;
    digit_blank = 1'b0;
    an_next     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        nibble      = shown[4*i +: 4];
        digit_blank = bus.blank_mask[i] | lz_blank[i];
        an_next[i]  = 1'b0;
      end
    end
    // Guard time overrides the anode select; blanking only darkens the
    // segments and leaves the anode driven so scan timing is unchanged.
    if (guard) begin
      an_next = '1;
    end
    seg_next = (guard || digit_blank) ? SEG_OFF : font_seg;
  end

  seg7_hex_font u_font (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler       <= '0;
      digit_idx       <= '0;
      shown           <= '0;
      pending         <= '0;
      pend_vld        <= 1'b0;
      bus.seg_out     <= SEG_OFF;
      bus.an_out      <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + PW'(1);

      if (slot_end) begin
        digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + IW'(1);
      end

      // Registered alongside the digit_idx wrap, so it is high exactly in
      // the cycle digit_idx becomes 0.
      bus.frame_start <= frame_end;

      // A load landing on the commit cycle is the newest value, so it goes
      // straight to shown and nothing is left pending.
      if (frame_end && bus.load) begin
        shown    <= bus.value_in;
        pend_vld <= 1'b0;
      end else if (frame_end && pend_vld) begin
        shown    <= pending;
        pend_vld <= 1'b0;
      end else if (bus.load) begin
        pending  <= bus.value_in;
        pend_vld <= 1'b1;
      end

      bus.seg_out <= seg_next;
      bus.an_out  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with NUM_DIGITS=4, CLK_DIV=8,
//   GUARD_CYCLES=2. Honors LEADING_ZERO_BLANK_EN the same way as the design.
//   Offset j (1..32) counts clocks after a frame_start edge; the output seen
//   at offset j reflects slot (j-1)/8, phase (j-1)%8.
module tb_seg7_scan_driver;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Font values used by the expectations, written out by hand.
  localparam logic [6:0] F0 = 7'h40;
  localparam logic [6:0] F1 = 7'h79;
  localparam logic [6:0] F2 = 7'h24;
  localparam logic [6:0] F3 = 7'h30;
  localparam logic [6:0] F5 = 7'h12;
  localparam logic [6:0] F8 = 7'h00;
  localparam logic [6:0] FA = 7'h08;
  localparam logic [6:0] FF = 7'h0E;
  localparam logic [6:0] OFF = 7'h7F;

  // ---------------------------------------------------------------------
  // Expected-value model for a frame offset
  // ---------------------------------------------------------------------
  function automatic logic [3:0] exp_an(input int j);
    int p;
    int d;
    p = (j - 1) % 8;
    d = (j - 1) / 8;
    return (p < 2) ? 4'hF : ~(4'b0001 << d);
  endfunction

  // digs = {d3, d2, d1, d0}, each the 7-bit pattern the digit should show.
  function automatic logic [6:0] exp_seg(input int j, input logic [27:0] digs);
    int p;
    int d;
    p = (j - 1) % 8;
    d = (j - 1) / 8;
    return (p < 2) ? OFF : digs[7*d +: 7];
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded sync to a frame boundary; returns at once if already on one.
  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_sync: frame_start=%b required 1 within 40 clks",
               name, bus.frame_start);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    bus.value_in   = 16'h0000;
    bus.load       = 1'b0;
    bus.blank_mask = 4'b0000;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.seg_out !== OFF || bus.an_out !== 4'hF || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: seg=%h an=%h fs=%b required seg=7f an=f fs=0",
               bus.seg_out, bus.an_out, bus.frame_start);
    end
    rst = 1'b0;
    // First frame after release: shown=0, every active phase shows 40.
    for (int j = 1; j <= 32; j++) begin
      step();
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F0, F0, F0, F0}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL reset_scan j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F0, F0, F0, F0}), (j == 32));
      end
    end
  endtask

  task automatic test_load_commit();
    wait_frame("load_commit");
    // Load mid-frame: the current frame keeps the old digits.
    for (int j = 1; j <= 32; j++) begin
      if (j == 6) begin
        bus.value_in = 16'h12AF;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F0, F0, F0, F0}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL load_hold j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F0, F0, F0, F0}), (j == 32));
      end
    end
    // Next frame: 0E,08,24,79 across digits 0..3.
    for (int j = 1; j <= 32; j++) begin
      step();
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F1, F2, FA, FF}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL load_show j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F1, F2, FA, FF}), (j == 32));
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_frame("back_to_back");
    // Two loads in one frame; 12AF stays on screen until the wrap.
    for (int j = 1; j <= 32; j++) begin
      if (j == 3) begin
        bus.value_in = 16'h1111;
        bus.load     = 1'b1;
      end
      if (j == 10) begin
        bus.value_in = 16'h2222;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F1, F2, FA, FF}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL b2b_hold j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F1, F2, FA, FF}), (j == 32));
      end
    end
    // Last load wins: all 24. A load on the commit edge (j=32) takes 3333.
    for (int j = 1; j <= 32; j++) begin
      if (j == 32) begin
        bus.value_in = 16'h3333;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F2, F2, F2, F2}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL b2b_last j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F2, F2, F2, F2}), (j == 32));
      end
    end
    for (int j = 1; j <= 32; j++) begin
      step();
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F3, F3, F3, F3}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL b2b_commit_edge j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F3, F3, F3, F3}), (j == 32));
      end
    end
  endtask

  task automatic test_blank_mask();
    wait_frame("blank_mask");
    for (int j = 1; j <= 32; j++) begin
      if (j == 5) begin
        bus.value_in = 16'h8888;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F3, F3, F3, F3})) begin
        errors++;
        $display("FAIL blank_pre j=%0d: an=%h seg=%h required an=%h seg=%h",
                 j, bus.an_out, bus.seg_out, exp_an(j), exp_seg(j, {F3, F3, F3, F3}));
      end
    end
    // Digit 2 darkened, its anode (B) still pulled low.
    bus.blank_mask = 4'b0100;
    for (int j = 1; j <= 32; j++) begin
      step();
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F8, OFF, F8, F8}) ||
          bus.frame_start !== (j == 32)) begin
        errors++;
        $display("FAIL blank_mask j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 j, bus.an_out, bus.seg_out, bus.frame_start,
                 exp_an(j), exp_seg(j, {F8, OFF, F8, F8}), (j == 32));
      end
    end
    bus.blank_mask = 4'b0000;
  endtask

  task automatic test_leading_zero();
    logic [27:0] exp_50;
    logic [27:0] exp_00;
`ifdef LEADING_ZERO_BLANK_EN
    exp_50 = {OFF, OFF, F5, F0};
    exp_00 = {OFF, OFF, OFF, F0};
`else
    exp_50 = {F0, F0, F5, F0};
    exp_00 = {F0, F0, F0, F0};
`endif
    wait_frame("leading_zero");
    for (int j = 1; j <= 32; j++) begin
      if (j == 5) begin
        bus.value_in = 16'h0050;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F8, F8, F8, F8})) begin
        errors++;
        $display("FAIL lz_pre j=%0d: an=%h seg=%h required an=%h seg=%h",
                 j, bus.an_out, bus.seg_out, exp_an(j), exp_seg(j, {F8, F8, F8, F8}));
      end
    end
    for (int j = 1; j <= 32; j++) begin
      if (j == 5) begin
        bus.value_in = 16'h0000;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, exp_50)) begin
        errors++;
        $display("FAIL lz_0050 j=%0d: an=%h seg=%h required an=%h seg=%h",
                 j, bus.an_out, bus.seg_out, exp_an(j), exp_seg(j, exp_50));
      end
    end
    for (int j = 1; j <= 32; j++) begin
      step();
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, exp_00)) begin
        errors++;
        $display("FAIL lz_0000 j=%0d: an=%h seg=%h required an=%h seg=%h",
                 j, bus.an_out, bus.seg_out, exp_an(j), exp_seg(j, exp_00));
      end
    end
  endtask

  task automatic test_mid_reset();
    wait_frame("mid_reset");
    // Put a non-zero value on screen first.
    for (int j = 1; j <= 32; j++) begin
      if (j == 2) begin
        bus.value_in = 16'hAAAA;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
    end
    // Pending 5555, then reset in the middle of slot 1.
    for (int j = 1; j <= 12; j++) begin
      if (j == 4) begin
        bus.value_in = 16'h5555;
        bus.load     = 1'b1;
      end
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {FA, FA, FA, FA})) begin
        errors++;
        $display("FAIL mid_reset_pre j=%0d: an=%h seg=%h required an=%h seg=%h",
                 j, bus.an_out, bus.seg_out, exp_an(j), exp_seg(j, {FA, FA, FA, FA}));
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.seg_out !== OFF || bus.an_out !== 4'hF || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: seg=%h an=%h fs=%b required seg=7f an=f fs=0",
               bus.seg_out, bus.an_out, bus.frame_start);
    end
    rst = 1'b0;
    // Scan restarts at digit 0 with shown=0; the pending 5555 never appears.
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 32; j++) begin
        step();
        checks++;
        if (bus.an_out !== exp_an(j) || bus.seg_out !== exp_seg(j, {F0, F0, F0, F0}) ||
            bus.frame_start !== (j == 32)) begin
          errors++;
          $display("FAIL mid_reset_scan f=%0d j=%0d: an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                   f, j, bus.an_out, bus.seg_out, bus.frame_start,
                   exp_an(j), exp_seg(j, {F0, F0, F0, F0}), (j == 32));
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_load_commit();
    test_back_to_back();
    test_blank_mask();
    test_leading_zero();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
